// File: rtl/fifo_pkg.sv
// Shared pointer constants and Gray/binary helpers for the dual-clock FIFO.
// Used by both the write-side (wptr_full) and read-side (rptr_empty) logic.
package fifo_pkg;

  localparam int ADDRSIZE_DFLT = 3;
  localparam int PTRSIZE = ADDRSIZE_DFLT + 1;
  localparam int DEPTH = 2 ** ADDRSIZE_DFLT;
  localparam int AFULL_DFLT = 6;

  typedef logic [PTRSIZE-1:0] ptr_t;

  // 32-bit so any narrower pointer can be zero-extended in and truncated out
  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write and read sides for level computation.
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic [WIDTH-1:0] b;

  always_comb begin
    b = gray;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gray[i];
    end
    bin = b;
  end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer, full flag, level and overflow for the async FIFO.
// Optional walmost_full output is enabled by defining WPTR_ALMOST_FULL_EN.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DFLT,
  parameter int AFULL_THRESH = AFULL_DFLT
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wen,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wlevel,
`ifdef WPTR_ALMOST_FULL_EN
  output logic                walmost_full,
`endif
  output logic                wovf
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_ptr;
  logic          wfull_q, wfull_d;
  logic          wovf_q, wovf_d;
  logic          accept;
`ifdef WPTR_ALMOST_FULL_EN
  logic          walmost_q, walmost_d;
`endif

  gray2bin_conv #(
    .WIDTH(PW)
  ) u_rptr_g2b (
    .gray(wq2_rptr),
    .bin (rbin_s)
  );

  always_comb begin
    accept = winc & ~wfull_q;
    wbin_d = wbin_q + PW'(accept);
    wptr_d = PW'(bin2gray(32'(wbin_d)));
    // full when the write pointer is one lap ahead: top two Gray bits inverted
    full_ptr = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                wq2_rptr[ADDRSIZE-2:0]};
    wfull_d = (wptr_d == full_ptr);
    wlevel_d = wbin_d - rbin_s;
    wovf_d = wovf_q | (winc & wfull_q);
`ifdef WPTR_ALMOST_FULL_EN
    walmost_d = (int'(wlevel_d) >= AFULL_THRESH);
`endif
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wovf_q   <= 1'b0;
`ifdef WPTR_ALMOST_FULL_EN
      walmost_q <= 1'b0;
`endif
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wovf_q   <= wovf_d;
`ifdef WPTR_ALMOST_FULL_EN
      walmost_q <= walmost_d;
`endif
    end
  end

  assign wptr   = wptr_q;
  assign waddr  = wbin_q[ADDRSIZE-1:0];
  assign wen    = winc & ~wfull_q;
  assign wfull  = wfull_q;
  assign wlevel = wlevel_q;
  assign wovf   = wovf_q;
`ifdef WPTR_ALMOST_FULL_EN
  assign walmost_full = walmost_q;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Directed self-checking bench for wptr_full (ADDRSIZE=3).
// Almost-full checks are built when WPTR_ALMOST_FULL_EN is defined.
module tb_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [3:0] wq2_rptr;
  logic [3:0] wptr;
  logic [2:0] waddr;
  logic       wen;
  logic       wfull;
  logic [3:0] wlevel;
  logic       wovf;
`ifdef WPTR_ALMOST_FULL_EN
  logic       walmost_full;
`endif

  int total = 0;
  int bad = 0;

  wptr_full #(
    .ADDRSIZE(3),
    .AFULL_THRESH(6)
  ) dut (
    .wclk    (wclk),
    .wrst    (wrst),
    .winc    (winc),
    .wq2_rptr(wq2_rptr),
    .wptr    (wptr),
    .waddr   (waddr),
    .wen     (wen),
    .wfull   (wfull),
    .wlevel  (wlevel),
`ifdef WPTR_ALMOST_FULL_EN
    .walmost_full(walmost_full),
`endif
    .wovf    (wovf)
  );

  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    winc = 1'b1;
    wq2_rptr = 4'b0000;
    tick();
    tick();
    total++;
    if (wptr !== 4'b0000) begin
      bad++;
      $display("FAIL reset_wptr got=%b want=0000", wptr);
    end
    total++;
    if (waddr !== 3'd0) begin
      bad++;
      $display("FAIL reset_waddr got=%0d want=0", waddr);
    end
    total++;
    if (wfull !== 1'b0) begin
      bad++;
      $display("FAIL reset_wfull got=%b want=0", wfull);
    end
    total++;
    if (wlevel !== 4'd0) begin
      bad++;
      $display("FAIL reset_wlevel got=%0d want=0", wlevel);
    end
    total++;
    if (wovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_wovf got=%b want=0", wovf);
    end
    wrst = 1'b0;
    winc = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] exp_g [8];
    exp_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
              4'b0111, 4'b0101, 4'b0100, 4'b1100};
    wq2_rptr = 4'b0000;
    winc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (wptr !== exp_g[i]) begin
        bad++;
        $display("FAIL fill_wptr[%0d] got=%b want=%b", i, wptr, exp_g[i]);
      end
      total++;
      if (wfull !== (i == 7)) begin
        bad++;
        $display("FAIL fill_wfull[%0d] got=%b want=%b", i, wfull, (i == 7));
      end
      total++;
      if (wlevel !== 4'(i + 1)) begin
        bad++;
        $display("FAIL fill_wlevel[%0d] got=%0d want=%0d", i, wlevel, i + 1);
      end
    end
    total++;
    if (wen !== 1'b0) begin
      bad++;
      $display("FAIL fill_wen_when_full got=%b want=0", wen);
    end
  endtask

  task automatic test_overflow();
    winc = 1'b1;
    tick();
    tick();
    total++;
    if (wptr !== 4'b1100) begin
      bad++;
      $display("FAIL ovf_wptr got=%b want=1100", wptr);
    end
    total++;
    if (waddr !== 3'd0) begin
      bad++;
      $display("FAIL ovf_waddr got=%0d want=0", waddr);
    end
    total++;
    if (wovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_wovf got=%b want=1", wovf);
    end
    total++;
    if (wlevel !== 4'd8) begin
      bad++;
      $display("FAIL ovf_wlevel got=%0d want=8", wlevel);
    end
    winc = 1'b0;
    tick();
    total++;
    if (wovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", wovf);
    end
  endtask

  task automatic test_drain_release();
    wq2_rptr = 4'b0001;
    tick();
    total++;
    if (wfull !== 1'b0) begin
      bad++;
      $display("FAIL drain_wfull got=%b want=0", wfull);
    end
    total++;
    if (wlevel !== 4'd7) begin
      bad++;
      $display("FAIL drain_wlevel got=%0d want=7", wlevel);
    end
    total++;
    if (wen !== 1'b0) begin
      bad++;
      $display("FAIL drain_wen_idle got=%b want=0", wen);
    end
    winc = 1'b1;
    tick();
    winc = 1'b0;
    total++;
    if (wptr !== 4'b1101) begin
      bad++;
      $display("FAIL drain_wptr got=%b want=1101", wptr);
    end
    total++;
    if (wfull !== 1'b1) begin
      bad++;
      $display("FAIL drain_refull got=%b want=1", wfull);
    end
    total++;
    if (wovf !== 1'b1) begin
      bad++;
      $display("FAIL drain_wovf_kept got=%b want=1", wovf);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] wb;
    logic [3:0] g;
    wrst = 1'b1;
    winc = 1'b0;
    wq2_rptr = 4'b0000;
    tick();
    wrst = 1'b0;
    total++;
    if (wovf !== 1'b0) begin
      bad++;
      $display("FAIL wrap_wovf_cleared got=%b want=0", wovf);
    end
    wb = 4'd0;
    winc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wq2_rptr = wb ^ (wb >> 1);
      tick();
      wb = wb + 4'd1;
      g = wb ^ (wb >> 1);
      total++;
      if (wptr !== g) begin
        bad++;
        $display("FAIL wrap_wptr[%0d] got=%b want=%b", i, wptr, g);
      end
      total++;
      if (wfull !== 1'b0) begin
        bad++;
        $display("FAIL wrap_wfull[%0d] got=%b want=0", i, wfull);
      end
      total++;
      if (wlevel !== 4'd1) begin
        bad++;
        $display("FAIL wrap_wlevel[%0d] got=%0d want=1", i, wlevel);
      end
    end
    winc = 1'b0;
    total++;
    if (wptr !== 4'b0000 || waddr !== 3'd0) begin
      bad++;
      $display("FAIL wrap_end got=%b/%0d want=0000/0", wptr, waddr);
    end
  endtask

`ifdef WPTR_ALMOST_FULL_EN
  task automatic test_almost_full();
    wrst = 1'b1;
    winc = 1'b0;
    wq2_rptr = 4'b0000;
    tick();
    wrst = 1'b0;
    total++;
    if (walmost_full !== 1'b0) begin
      bad++;
      $display("FAIL afull_reset got=%b want=0", walmost_full);
    end
    winc = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (walmost_full !== (i >= 6)) begin
        bad++;
        $display("FAIL afull_rise[%0d] got=%b want=%b", i, walmost_full, (i >= 6));
      end
    end
    winc = 1'b0;
    wq2_rptr = 4'b0001;
    tick();
    total++;
    if (walmost_full !== 1'b0 || wlevel !== 4'd5) begin
      bad++;
      $display("FAIL afull_fall got=%b/%0d want=0/5", walmost_full, wlevel);
    end
  endtask
`endif

  initial begin
    wrst = 1'b1;
    winc = 1'b0;
    wq2_rptr = 4'b0000;
    test_reset();
    test_fill();
    test_overflow();
    test_drain_release();
    test_wrap();
`ifdef WPTR_ALMOST_FULL_EN
    test_almost_full();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
